fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID latch.
- Holds the PC and issues instruction-memory reads with an ihit handshake.
- Hands each instruction and its PC+4 to the latch via instr_valid (latch enable) and flush_out (latch flush).
- Handles downstream stalls, branch/jump redirects and the halt instruction.

---
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID latch: owns the PC, issues imem reads,
// and hands instructions downstream while absorbing stalls, redirects and halt.
module fetch_stage #(
    parameter logic [31:0] PC_INIT    = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        iren,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_out,
    output logic [31:0] pc_plus_4,
    output logic        instr_valid,
    output logic        flush_out,
    output logic        halt,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_DROP   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buffer;
    logic [31:0] r_pending;
    logic        r_halt;

    state_t      w_state_n;
    logic [31:0] w_pc_n;
    logic [31:0] w_buffer_n;
    logic [31:0] w_pending_n;
    logic        w_halt_n;
    logic [31:0] w_pc_inc;

    assign w_pc_inc  = r_pc + 32'd4;
    assign imemaddr  = r_pc;
    assign pc_plus_4 = w_pc_inc;
    assign halt      = r_halt;
    assign dbg_state = r_state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_FETCH;
            r_pc      <= PC_INIT;
            r_buffer  <= 32'd0;
            r_pending <= 32'd0;
            r_halt    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_pc      <= w_pc_n;
            r_buffer  <= w_buffer_n;
            r_pending <= w_pending_n;
            r_halt    <= w_halt_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_pc_n      = r_pc;
        w_buffer_n  = r_buffer;
        w_pending_n = r_pending;
        w_halt_n    = r_halt;
        iren        = 1'b0;
        instr_out   = 32'd0;
        instr_valid = 1'b0;
        flush_out   = 1'b0;
        case (r_state)
            S_FETCH: begin
                iren      = 1'b1;
                instr_out = imemload;
                flush_out = redirect;
                if (redirect) begin
                    // Without ihit the read is still in flight at the old PC; park the target.
                    if (ihit) begin
                        w_pc_n = redirect_pc;
                    end else begin
                        w_pending_n = redirect_pc;
                        w_state_n   = S_DROP;
                    end
                end else if (ihit) begin
                    if (!stall) begin
                        instr_valid = 1'b1;
                        w_pc_n      = w_pc_inc;
                        if (imemload == HALT_INSTR) begin
                            w_state_n = S_HALTED;
                            w_halt_n  = 1'b1;
                        end
                    end else begin
                        w_buffer_n = imemload;
                        w_state_n  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                instr_out = r_buffer;
                flush_out = redirect;
                if (redirect) begin
                    w_pc_n    = redirect_pc;
                    w_state_n = S_FETCH;
                end else if (!stall) begin
                    instr_valid = 1'b1;
                    w_pc_n      = w_pc_inc;
                    if (r_buffer == HALT_INSTR) begin
                        w_state_n = S_HALTED;
                        w_halt_n  = 1'b1;
                    end else begin
                        w_state_n = S_FETCH;
                    end
                end
            end
            S_DROP: begin
                iren      = 1'b1;
                flush_out = redirect;
                if (redirect) begin
                    w_pending_n = redirect_pc;
                end
                if (ihit) begin
                    w_pc_n    = redirect ? redirect_pc : r_pending;
                    w_state_n = S_FETCH;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenario tasks plus a hand-off scoreboard that
// pops {instr, pc+4} pairs whenever instr_valid is seen.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        ihit;
    logic [31:0] imemload;
    logic        iren;
    logic [31:0] imemaddr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] pc_plus_4;
    logic        instr_valid;
    logic        flush_out;
    logic        halt;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_DROP   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    fetch_stage dut (
        .CLK(clk), .RST(rst), .ihit(ihit), .imemload(imemload), .iren(iren),
        .imemaddr(imemaddr), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_out(instr_out), .pc_plus_4(pc_plus_4),
        .instr_valid(instr_valid), .flush_out(flush_out), .halt(halt),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: inputs change at negedge, outputs sampled 4 ns later
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (instr_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL handoff_unexpected: got instr=%h pc4=%h, expected no hand-off",
                             instr_out, pc_plus_4);
                end else begin
                    e = exp_q.pop_front();
                    if ({instr_out, pc_plus_4} !== e) begin
                        errors++;
                        $display("FAIL handoff_data: got instr=%h pc4=%h, expected instr=%h pc4=%h",
                                 instr_out, pc_plus_4, e[63:32], e[31:0]);
                    end
                end
            end
        end
    end

    task automatic drive(input logic h, input logic [31:0] d, input logic s,
                         input logic r, input logic [31:0] rp);
        @(negedge clk);
        ihit = h; imemload = d; stall = s; redirect = r; redirect_pc = rp;
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        return $urandom & 32'h7FFF_FFFF;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({iren, imemaddr, halt, instr_valid, dbg_state, pc_plus_4} !==
            {1'b1, 32'h0, 1'b0, 1'b0, ST_FETCH, 32'h4}) begin
            errors++;
            $display("FAIL reset_state: got iren=%b addr=%h halt=%b vld=%b st=%0d pc4=%h, expected 1 0 0 0 0 4",
                     iren, imemaddr, halt, instr_valid, dbg_state, pc_plus_4);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words[2];
        words[0] = 32'h2001_0005;
        words[1] = 32'h2002_0007;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, words[i], 1'b0, 1'b0, 32'd0);
            exp_q.push_back({words[i], 32'(4 * i + 4)});
            checks++;
            if (imemaddr !== 32'(4 * i) || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_addr_%0d: got addr=%h vld=%b, expected addr=%h vld=1",
                         i, imemaddr, instr_valid, 32'(4 * i));
            end
        end
        // two more hand-offs to bring the PC to 0x10
        for (int i = 2; i < 4; i++) begin
            logic [31:0] w;
            w = rand_word();
            drive(1'b1, w, 1'b0, 1'b0, 32'd0);
            exp_q.push_back({w, 32'(4 * i + 4)});
        end
    endtask

    task automatic test_ihit_delay();
        logic [31:0] w;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
            checks++;
            if (iren !== 1'b1 || imemaddr !== 32'h10 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_%0d: got iren=%b addr=%h vld=%b, expected 1 00000010 0",
                         i, iren, imemaddr, instr_valid);
            end
        end
        w = rand_word();
        drive(1'b1, w, 1'b0, 1'b0, 32'd0);
        exp_q.push_back({w, 32'h14});
        checks++;
        if (pc_plus_4 !== 32'h14 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_hit: got pc4=%h vld=%b, expected 00000014 1", pc_plus_4, instr_valid);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 32'hAC22_0000, 1'b1, 1'b0, 32'd0);
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_hit_valid: got %b, expected 0", instr_valid);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, rand_word(), 1'b1, 1'b0, 32'd0);
            checks++;
            if (dbg_state !== ST_HOLD || iren !== 1'b0 || instr_out !== 32'hAC22_0000 ||
                imemaddr !== 32'h14 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: got st=%0d iren=%b instr=%h addr=%h vld=%b, expected 1 0 ac220000 00000014 0",
                         i, dbg_state, iren, instr_out, imemaddr, instr_valid);
            end
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        exp_q.push_back({32'hAC22_0000, 32'h18});
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (imemaddr !== 32'h18 || dbg_state !== ST_FETCH) begin
            errors++;
            $display("FAIL hold_release: got addr=%h st=%0d, expected 00000018 0", imemaddr, dbg_state);
        end
        for (int i = 0; i < 2; i++) begin
            logic [31:0] w;
            w = rand_word();
            drive(1'b1, w, 1'b0, 1'b0, 32'd0);
            exp_q.push_back({w, 32'(32'h1C + 4 * i)});
        end
    endtask

    task automatic test_redirect_drop();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h400);
        checks++;
        if (flush_out !== 1'b1 || instr_valid !== 1'b0 || imemaddr !== 32'h20) begin
            errors++;
            $display("FAIL drop_enter: got flush=%b vld=%b addr=%h, expected 1 0 00000020",
                     flush_out, instr_valid, imemaddr);
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (dbg_state !== ST_DROP || iren !== 1'b1 || imemaddr !== 32'h20 || flush_out !== 1'b0) begin
            errors++;
            $display("FAIL drop_wait: got st=%0d iren=%b addr=%h flush=%b, expected 2 1 00000020 0",
                     dbg_state, iren, imemaddr, flush_out);
        end
        drive(1'b1, rand_word(), 1'b0, 1'b0, 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (imemaddr !== 32'h400 || dbg_state !== ST_FETCH) begin
            errors++;
            $display("FAIL drop_target: got addr=%h st=%0d, expected 00000400 0", imemaddr, dbg_state);
        end
        // second redirect while dropping: last one wins
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h600);
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h500);
        drive(1'b1, rand_word(), 1'b0, 1'b0, 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (imemaddr !== 32'h500) begin
            errors++;
            $display("FAIL drop_last_wins: got addr=%h, expected 00000500", imemaddr);
        end
    endtask

    task automatic test_redirect_same_cycle();
        drive(1'b1, rand_word(), 1'b0, 1'b1, 32'h80);
        checks++;
        if (instr_valid !== 1'b0 || flush_out !== 1'b1) begin
            errors++;
            $display("FAIL redir_hit: got vld=%b flush=%b, expected 0 1", instr_valid, flush_out);
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (imemaddr !== 32'h80) begin
            errors++;
            $display("FAIL redir_hit_addr: got %h, expected 00000080", imemaddr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        drive(1'b1, rand_word(), 1'b0, 1'b1, 32'hFFFF_FFFC);
        w = rand_word();
        drive(1'b1, w, 1'b0, 1'b0, 32'd0);
        exp_q.push_back({w, 32'h0});
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (imemaddr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr: got %h, expected 00000000", imemaddr);
        end
    endtask

    task automatic test_halt();
        drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        exp_q.push_back({32'hFFFF_FFFF, 32'h4});
        checks++;
        if (halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_early: got %b, expected 0", halt);
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (halt !== 1'b1 || iren !== 1'b0 || dbg_state !== ST_HALTED) begin
            errors++;
            $display("FAIL halted: got halt=%b iren=%b st=%0d, expected 1 0 3", halt, iren, dbg_state);
        end
        drive(1'b1, rand_word(), 1'b0, 1'b1, 32'h900);
        checks++;
        if (flush_out !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL halted_redirect: got flush=%b vld=%b, expected 0 0", flush_out, instr_valid);
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (imemaddr !== 32'h4 || halt !== 1'b1) begin
            errors++;
            $display("FAIL halted_ignore: got addr=%h halt=%b, expected 00000004 1", imemaddr, halt);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (halt !== 1'b0 || imemaddr !== 32'h0 || iren !== 1'b1) begin
            errors++;
            $display("FAIL halt_reset: got halt=%b addr=%h iren=%b, expected 0 00000000 1",
                     halt, imemaddr, iren);
        end
    endtask

    task automatic test_reset_in_drop();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h700);
        drive(1'b1, 32'd0, 1'b0, 1'b0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ihit = 1'b0;
        #1;
        checks++;
        if (dbg_state !== ST_FETCH || imemaddr !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_reset: got st=%0d addr=%h vld=%b, expected 0 00000000 0",
                     dbg_state, imemaddr, instr_valid);
        end
    endtask

    initial begin
        rst = 1'b1; ihit = 1'b0; imemload = 32'd0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = 32'd0;
        test_reset();
        test_back_to_back();
        test_ihit_delay();
        test_stall();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_wrap();
        test_halt();
        test_reset_in_drop();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL handoff_missing: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
